// File: rtl/keyboard_pkg.sv
// keyboard_pkg: scancodes, Gigatron button codes and layout selection shared by the keyboard block
package keyboard_pkg;
    localparam logic [7:0] IDLE_CODE  = 8'hFF;
    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CTRL    = 8'h14;
    localparam logic [7:0] SC_CAPS    = 8'h58;
    localparam logic [7:0] SC_RIGHT   = 8'h74;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_DOWN    = 8'h72;
    localparam logic [7:0] SC_UP      = 8'h75;
    localparam logic [7:0] SC_PGUP    = 8'h7D;
    localparam logic [7:0] SC_PGDN    = 8'h7A;
    localparam logic [7:0] SC_ENTER   = 8'h5A;
    localparam logic [7:0] SC_BKSP    = 8'h66;
    localparam logic [7:0] SC_ESC     = 8'h76;
    localparam logic [7:0] SC_TAB     = 8'h0D;
    localparam logic [7:0] SC_SPACE   = 8'h29;
    localparam logic [7:0] SC_Y       = 8'h35;
    localparam logic [7:0] SC_Z       = 8'h1A;
    localparam logic [7:0] BTN_RIGHT  = 8'hFE;
    localparam logic [7:0] BTN_LEFT   = 8'hFD;
    localparam logic [7:0] BTN_DOWN   = 8'hFB;
    localparam logic [7:0] BTN_UP     = 8'hF7;
    localparam logic [7:0] BTN_START  = 8'hEF;
    localparam logic [7:0] BTN_SELECT = 8'hDF;
    typedef enum logic [2:0] {LANG_US = 3'd0, LANG_DE = 3'd1} lang_e;
endpackage

// File: rtl/keyboard_scancode_map.sv
// keyboard_scancode_map: combinational set-2 scancode to Gigatron code translation
module keyboard_scancode_map
    import keyboard_pkg::*;
(
    input  logic [8:0] scan_i,
    input  logic       shift_i,
    input  logic       caps_i,
    input  logic       ctrl_i,
    input  logic [2:0] kb_lang_i,
    output logic       valid_o,
    output logic [7:0] code_o
);
    logic        ext;
    logic        de;
    logic [7:0]  sc;
    logic [7:0]  lower;
    logic [15:0] pair;
    assign ext = scan_i[8];
    assign de  = kb_lang_i == LANG_DE;
    assign sc  = (de && scan_i[7:0] == SC_Z) ? SC_Y : (de && scan_i[7:0] == SC_Y) ? SC_Z : scan_i[7:0];
    always_comb begin
        lower = 8'h00;
        case (sc)
            8'h1C: lower = "a"; 8'h32: lower = "b"; 8'h21: lower = "c"; 8'h23: lower = "d";
            8'h24: lower = "e"; 8'h2B: lower = "f"; 8'h34: lower = "g"; 8'h33: lower = "h";
            8'h43: lower = "i"; 8'h3B: lower = "j"; 8'h42: lower = "k"; 8'h4B: lower = "l";
            8'h3A: lower = "m"; 8'h31: lower = "n"; 8'h44: lower = "o"; 8'h4D: lower = "p";
            8'h15: lower = "q"; 8'h2D: lower = "r"; 8'h1B: lower = "s"; 8'h2C: lower = "t";
            8'h3C: lower = "u"; 8'h2A: lower = "v"; 8'h1D: lower = "w"; 8'h22: lower = "x";
            8'h35: lower = "y"; 8'h1A: lower = "z";
            default: lower = 8'h00;
        endcase
    end
    always_comb begin
        pair = 16'h0000;
        case (sc)
            8'h16: pair = {"1", "!"}; 8'h1E: pair = {"2", "@"}; 8'h26: pair = {"3", "#"};
            8'h25: pair = {"4", "$"}; 8'h2E: pair = {"5", "%"}; 8'h36: pair = {"6", "^"};
            8'h3D: pair = {"7", "&"}; 8'h3E: pair = {"8", "*"}; 8'h46: pair = {"9", "("};
            8'h45: pair = {"0", ")"}; 8'h0E: pair = {8'h60, "~"}; 8'h4E: pair = {"-", "_"};
            8'h55: pair = {"=", "+"}; 8'h54: pair = {"[", "{"}; 8'h5B: pair = {"]", "}"};
            8'h5D: pair = {"\\", "|"}; 8'h4C: pair = {";", ":"}; 8'h52: pair = {"'", "\""};
            8'h41: pair = {",", "<"}; 8'h49: pair = {".", ">"}; 8'h4A: pair = {"/", "?"};
            SC_SPACE: pair = {8'h20, 8'h20};
            SC_ENTER: pair = {8'h0A, 8'h0A};
            SC_BKSP:  pair = {8'h7F, 8'h7F};
            SC_TAB:   pair = {8'h09, 8'h09};
            SC_ESC:   pair = {8'h1B, 8'h1B};
            default:  pair = 16'h0000;
        endcase
    end
    always_comb begin
        valid_o = 1'b0;
        code_o  = IDLE_CODE;
        if (ext) begin
            valid_o = 1'b1;
            case (scan_i[7:0])
                SC_RIGHT: code_o = BTN_RIGHT;
                SC_LEFT:  code_o = BTN_LEFT;
                SC_DOWN:  code_o = BTN_DOWN;
                SC_UP:    code_o = BTN_UP;
                SC_PGUP:  code_o = BTN_START;
                SC_PGDN:  code_o = BTN_SELECT;
                SC_ENTER: code_o = 8'h0A;
                default:  valid_o = 1'b0;
            endcase
        end else if (lower != 8'h00) begin
            valid_o = 1'b1;
            code_o  = ctrl_i ? (lower & 8'h1F) : (shift_i ^ caps_i) ? lower - 8'h20 : lower;
        end else if (pair != 16'h0000) begin
            valid_o = 1'b1;
            code_o  = shift_i ? pair[7:0] : pair[15:8];
        end
    end
endmodule

// File: rtl/keyboard.sv
// keyboard: PS/2 key events to a single held-key Gigatron code, latched on the controller pulse
module keyboard #(
    parameter logic [7:0] IDLE_CODE = keyboard_pkg::IDLE_CODE
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        pulse,
    input  logic [2:0]  kb_lang,
    output logic [7:0]  ascii_code,
    output logic        caps_lock
);
    import keyboard_pkg::*;
    logic       tog_q, pulse_q;
    logic       lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d, caps_q, caps_d;
    logic [7:0] pending_q, pending_d, ascii_q, ascii_d;
    logic [8:0] held_q, held_d;
    logic [8:0] scan;
    logic       press, ev, map_valid;
    logic [7:0] map_code;
    assign scan       = ps2_key[8:0];
    assign press      = ps2_key[9];
    assign ev         = ps2_key[10] != tog_q;
    assign ascii_code = ascii_q;
    assign caps_lock  = caps_q;
    keyboard_scancode_map u_map (
        .scan_i    (scan),
        .shift_i   (lshift_q | rshift_q),
        .caps_i    (caps_q),
        .ctrl_i    (ctrl_q),
        .kb_lang_i (kb_lang),
        .valid_o   (map_valid),
        .code_o    (map_code)
    );
    always_comb begin
        lshift_d  = lshift_q;
        rshift_d  = rshift_q;
        ctrl_d    = ctrl_q;
        caps_d    = caps_q;
        pending_d = pending_q;
        held_d    = held_q;
        if (ev) begin
            if (scan == {1'b0, SC_LSHIFT}) lshift_d = press;
            else if (scan == {1'b0, SC_RSHIFT}) rshift_d = press;
            else if (scan[7:0] == SC_CTRL) ctrl_d = press;
            else if (scan == {1'b0, SC_CAPS}) caps_d = caps_q ^ press;
            else if (press && map_valid) begin
                pending_d = map_code;
                held_d    = scan;
            end else if (!press && scan == held_q) pending_d = IDLE_CODE;
        end
        ascii_d = (pulse && !pulse_q) ? pending_q : ascii_q;
    end
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            tog_q     <= ps2_key[10];
            pulse_q   <= 1'b0;
            lshift_q  <= 1'b0;
            rshift_q  <= 1'b0;
            ctrl_q    <= 1'b0;
            caps_q    <= 1'b0;
            pending_q <= IDLE_CODE;
            held_q    <= 9'h000;
            ascii_q   <= IDLE_CODE;
        end else begin
            tog_q     <= ps2_key[10];
            pulse_q   <= pulse;
            lshift_q  <= lshift_d;
            rshift_q  <= rshift_d;
            ctrl_q    <= ctrl_d;
            caps_q    <= caps_d;
            pending_q <= pending_d;
            held_q    <= held_d;
            ascii_q   <= ascii_d;
        end
    end
endmodule

// File: tb/tb_keyboard.sv
// tb_keyboard: directed self-checking bench for the keyboard block
module tb_keyboard;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] ps2_key = 11'h000;
    logic        pulse = 1'b0;
    logic [2:0]  kb_lang = 3'd0;
    logic [7:0]  ascii_code;
    logic        caps_lock;
    int checks = 0;
    int errors = 0;
    // {ext, lang[2:0]}, scancode, expected code
    localparam logic [19:0] MAP_V [20] = '{
        20'h0_1C_61, 20'h0_1A_7A, 20'h0_35_79, 20'h1_1A_79, 20'h1_35_7A,
        20'h0_16_31, 20'h0_4A_2F, 20'h0_29_20, 20'h0_5A_0A, 20'h0_66_7F,
        20'h0_0D_09, 20'h0_76_1B, 20'h8_74_FE, 20'h8_6B_FD, 20'h8_72_FB,
        20'h8_75_F7, 20'h8_7D_EF, 20'h8_7A_DF, 20'h8_5A_0A, 20'h3_1A_7A
    };

    keyboard dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .pulse      (pulse),
        .kb_lang    (kb_lang),
        .ascii_code (ascii_code),
        .caps_lock  (caps_lock)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic ext, input logic prs, input logic [7:0] sc);
        ps2_key = {~ps2_key[10], prs, ext, sc};
        tick(2);
    endtask

    task automatic strobe();
        pulse = 1'b1;
        tick(2);
        pulse = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
        tick(2);
        reset = 1'b1;
        tick(1);
        checks++;
        if (ascii_code !== 8'hFF) begin errors++; $display("FAIL reset_ascii got %h want ff", ascii_code); end
        checks++;
        if (caps_lock !== 1'b0) begin errors++; $display("FAIL reset_caps got %b want 0", caps_lock); end
        strobe();
        checks++;
        if (ascii_code !== 8'hFF) begin errors++; $display("FAIL reset_no_event got %h want ff", ascii_code); end
    endtask

    task automatic test_map();
        for (int i = 0; i < 20; i++) begin
            kb_lang = MAP_V[i][18:16];
            send(MAP_V[i][19], 1'b1, MAP_V[i][15:8]);
            strobe();
            checks++;
            if (ascii_code !== MAP_V[i][7:0])
                begin errors++; $display("FAIL map_%0d got %h want %h", i, ascii_code, MAP_V[i][7:0]); end
            send(MAP_V[i][19], 1'b0, MAP_V[i][15:8]);
            strobe();
            checks++;
            if (ascii_code !== 8'hFF) begin errors++; $display("FAIL map_rel_%0d got %h want ff", i, ascii_code); end
        end
        kb_lang = 3'd0;
    endtask

    task automatic test_shift_caps();
        send(1'b0, 1'b1, 8'h12);
        send(1'b0, 1'b1, 8'h1C);
        strobe();
        checks++;
        if (ascii_code !== 8'h41) begin errors++; $display("FAIL shift_a got %h want 41", ascii_code); end
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b1, 8'h16);
        strobe();
        checks++;
        if (ascii_code !== 8'h21) begin errors++; $display("FAIL shift_1 got %h want 21", ascii_code); end
        send(1'b0, 1'b0, 8'h16);
        send(1'b0, 1'b0, 8'h12);
        send(1'b0, 1'b1, 8'h58);
        send(1'b0, 1'b0, 8'h58);
        checks++;
        if (caps_lock !== 1'b1) begin errors++; $display("FAIL caps_on got %b want 1", caps_lock); end
        send(1'b0, 1'b1, 8'h1C);
        strobe();
        checks++;
        if (ascii_code !== 8'h41) begin errors++; $display("FAIL caps_a got %h want 41", ascii_code); end
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b1, 8'h59);
        send(1'b0, 1'b1, 8'h1C);
        strobe();
        checks++;
        if (ascii_code !== 8'h61) begin errors++; $display("FAIL caps_shift_a got %h want 61", ascii_code); end
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h59);
        send(1'b0, 1'b1, 8'h58);
        send(1'b0, 1'b0, 8'h58);
        checks++;
        if (caps_lock !== 1'b0) begin errors++; $display("FAIL caps_off got %b want 0", caps_lock); end
        send(1'b0, 1'b1, 8'h1C);
        send(1'b0, 1'b1, 8'h12);
        strobe();
        checks++;
        if (ascii_code !== 8'h61) begin errors++; $display("FAIL shift_after_press got %h want 61", ascii_code); end
        send(1'b0, 1'b0, 8'h12);
        send(1'b0, 1'b0, 8'h1C);
        strobe();
    endtask

    task automatic test_ctrl();
        send(1'b0, 1'b1, 8'h14);
        send(1'b0, 1'b1, 8'h21);
        strobe();
        checks++;
        if (ascii_code !== 8'h03) begin errors++; $display("FAIL ctrl_c got %h want 03", ascii_code); end
        send(1'b0, 1'b0, 8'h21);
        send(1'b0, 1'b0, 8'h14);
        send(1'b1, 1'b1, 8'h14);
        send(1'b0, 1'b1, 8'h1C);
        strobe();
        checks++;
        if (ascii_code !== 8'h01) begin errors++; $display("FAIL rctrl_a got %h want 01", ascii_code); end
        send(1'b0, 1'b0, 8'h1C);
        send(1'b1, 1'b0, 8'h14);
        strobe();
    endtask

    task automatic test_release_other();
        send(1'b1, 1'b1, 8'h75);
        strobe();
        checks++;
        if (ascii_code !== 8'hF7) begin errors++; $display("FAIL up got %h want f7", ascii_code); end
        send(1'b0, 1'b1, 8'h1C);
        send(1'b1, 1'b0, 8'h75);
        strobe();
        checks++;
        if (ascii_code !== 8'h61) begin errors++; $display("FAIL stale_release got %h want 61", ascii_code); end
        send(1'b0, 1'b1, 8'h05);
        send(1'b0, 1'b0, 8'h05);
        strobe();
        checks++;
        if (ascii_code !== 8'h61) begin errors++; $display("FAIL unmapped got %h want 61", ascii_code); end
        send(1'b0, 1'b0, 8'h1C);
        strobe();
        checks++;
        if (ascii_code !== 8'hFF) begin errors++; $display("FAIL held_release got %h want ff", ascii_code); end
    endtask

    task automatic test_back_to_back();
        send(1'b0, 1'b1, 8'h1C);
        send(1'b0, 1'b1, 8'h32);
        strobe();
        checks++;
        if (ascii_code !== 8'h62) begin errors++; $display("FAIL last_wins got %h want 62", ascii_code); end
        send(1'b0, 1'b0, 8'h1C);
        strobe();
        checks++;
        if (ascii_code !== 8'h62) begin errors++; $display("FAIL old_release got %h want 62", ascii_code); end
        send(1'b0, 1'b0, 8'h32);
        strobe();
        checks++;
        if (ascii_code !== 8'hFF) begin errors++; $display("FAIL b2b_release got %h want ff", ascii_code); end
    endtask

    task automatic test_no_pulse_reset();
        send(1'b0, 1'b1, 8'h58);
        send(1'b0, 1'b1, 8'h1C);
        tick(6);
        checks++;
        if (ascii_code !== 8'hFF) begin errors++; $display("FAIL no_pulse got %h want ff", ascii_code); end
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        checks++;
        if (caps_lock !== 1'b0) begin errors++; $display("FAIL mid_reset_caps got %b want 0", caps_lock); end
        strobe();
        checks++;
        if (ascii_code !== 8'hFF) begin errors++; $display("FAIL mid_reset_pending got %h want ff", ascii_code); end
    endtask

    initial begin
        test_reset();
        test_map();
        test_shift_caps();
        test_ctrl();
        test_release_other();
        test_back_to_back();
        test_no_pulse_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
